clock_display_mux: RTL and testbench



---
 rtl/clock_display_pkg.sv | 26 ++
 rtl/clock_display_mux_bin2_to_bcd.sv | 39 +++
 rtl/clock_display_mux.sv | 177 +++++++++++++++++
 tb/tb_clock_display_mux.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// clock_display_pkg
// Shared constants for the multiplexed HH.MM.SS display: digit count,
// 7-segment codes ({g,f,e,d,c,b,a}, 1 = lit) and legal field limits.
// No ports.
package clock_display_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [5:0] HR_MAX  = 6'd23;

   // BCD digit to segment code; non-decimal codes go dark.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      if (d < 4'd10) return SEG_DIGIT[d];
      return SEG_BLANK;
   endfunction

endpackage

// File: rtl/clock_display_mux_bin2_to_bcd.sv
// bin2_to_bcd
// Combinational 6-bit binary to two BCD digits using a restoring
// compare/subtract chain (40, 20, 10), plus an out-of-range flag.
// Ports:
//   value  in  6  binary field value
//   limit  in  6  largest legal value of this field
//   tens   out 4  value / 10 (0..6)
//   ones   out 4  value % 10
//   over   out 1  value > limit
module bin2_to_bcd (
   input  logic [5:0] value,
   input  logic [5:0] limit,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       over
);

   logic [5:0] rem;

   always_comb begin
      rem  = value;
      tens = 4'd0;
      if (rem >= 6'd40) begin
         rem  = rem - 6'd40;
         tens = tens + 4'd4;
      end
      if (rem >= 6'd20) begin
         rem  = rem - 6'd20;
         tens = tens + 4'd2;
      end
      if (rem >= 6'd10) begin
         rem  = rem - 6'd10;
         tens = tens + 4'd1;
      end
      ones = rem[3:0];
      over = (value > limit);
   end

endmodule

// File: rtl/clock_display_mux.sv
// clock_display_mux
// Scans a 6-digit multiplexed 7-segment display showing HH.MM.SS. The
// time is snapshotted once per scan frame so a frame never mixes two
// different times.
// Optional build macro: CLOCK_DISPLAY_12H_EN selects 12-hour display with
// a PM indicator on the decimal point of digit 0.
// Ports:
//   clock        in  1  system clock
//   reset        in  1  asynchronous, active-high
//   sec          in  6  binary seconds (0..59)
//   min          in  6  binary minutes (0..59)
//   hr           in  5  binary hours   (0..23)
//   seg          out 7  segments {g,f,e,d,c,b,a}
//   dp           out 1  decimal point of the enabled digit
//   an           out 6  one-hot digit enable, an[0] = sec ones
//   frame_start  out 1  pulse on the cycle the snapshot is taken
module clock_display_mux
   import clock_display_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            sec,
   input  logic [5:0]            min,
   input  logic [4:0]            hr,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_start
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] prescale_reg;
   logic [2:0]    index_reg;
   logic          load_pending_reg;
   logic [5:0]    snap_sec_reg;
   logic [5:0]    snap_min_reg;
   logic [4:0]    snap_hr_reg;

   logic tc;
   logic take;

   assign tc   = (prescale_reg == PW'(SCAN_DIV - 1));
   assign take = load_pending_reg | (tc & (index_reg == 3'd5));

   // load_pending_reg resets to 1, so the pulse is masked while in reset.
   assign frame_start = take & ~reset;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescale_reg     <= '0;
         index_reg        <= 3'd0;
         load_pending_reg <= 1'b1;
         snap_sec_reg     <= '0;
         snap_min_reg     <= '0;
         snap_hr_reg      <= '0;
      end else begin
         load_pending_reg <= 1'b0;
         if (tc) begin
            prescale_reg <= '0;
            index_reg    <= (index_reg == 3'd5) ? 3'd0 : index_reg + 3'd1;
         end else begin
            prescale_reg <= prescale_reg + PW'(1);
         end
         if (take) begin
            snap_sec_reg <= sec;
            snap_min_reg <= min;
            snap_hr_reg  <= hr;
         end
      end
   end

   // On the very first frame the snapshot register is still loading while
   // digit 0 is being registered, so bypass it with the live inputs.
   logic [5:0] src_sec;
   logic [5:0] src_min;
   logic [4:0] src_hr;

   assign src_sec = load_pending_reg ? sec : snap_sec_reg;
   assign src_min = load_pending_reg ? min : snap_min_reg;
   assign src_hr  = load_pending_reg ? hr  : snap_hr_reg;

   logic [4:0] hour_disp;
   logic       pm;

`ifdef CLOCK_DISPLAY_12H_EN
   // Out-of-range hours pass through unchanged so the converter still
   // flags them and shows dashes.
   always_comb begin
      hour_disp = src_hr;
      if (src_hr == 5'd0)
         hour_disp = 5'd12;
      else if ((src_hr > 5'd12) && ({1'b0, src_hr} <= HR_MAX))
         hour_disp = src_hr - 5'd12;
      pm = (src_hr >= 5'd12) && ({1'b0, src_hr} <= HR_MAX);
   end
`else
   assign hour_disp = src_hr;
   assign pm        = 1'b0;
`endif

   // Field 0 = sec, 1 = min, 2 = hr; field f drives digits 2f (ones) and
   // 2f+1 (tens).
   logic [5:0] field_val [3];
   logic [5:0] field_lim [3];
   logic [3:0] field_tens [3];
   logic [3:0] field_ones [3];
   logic [2:0] field_over;
   logic [6:0] digit_seg [NUM_DIGITS];

   assign field_val[0] = src_sec;
   assign field_val[1] = src_min;
   assign field_val[2] = {1'b0, hour_disp};
   assign field_lim[0] = SEC_MAX;
   assign field_lim[1] = MIN_MAX;
   assign field_lim[2] = HR_MAX;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_field
         bin2_to_bcd u_conv (
            .value (field_val[gi]),
            .limit (field_lim[gi]),
            .tens  (field_tens[gi]),
            .ones  (field_ones[gi]),
            .over  (field_over[gi])
         );
         assign digit_seg[2*gi]   = field_over[gi] ? SEG_DASH : seg_code(field_ones[gi]);
         assign digit_seg[2*gi+1] = field_over[gi] ? SEG_DASH : seg_code(field_tens[gi]);
      end
   endgenerate

   logic [6:0]            seg_next;
   logic                  dp_next;
   logic [NUM_DIGITS-1:0] an_next;

   always_comb begin
      seg_next = SEG_BLANK;
      case (index_reg)
         3'd0:    seg_next = digit_seg[0];
         3'd1:    seg_next = digit_seg[1];
         3'd2:    seg_next = digit_seg[2];
         3'd3:    seg_next = digit_seg[3];
         3'd4:    seg_next = digit_seg[4];
         3'd5:    seg_next = digit_seg[5];
         default: seg_next = SEG_BLANK;
      endcase
      an_next = NUM_DIGITS'(1) << index_reg;
      // Separators follow MM (digit 2) and HH (digit 4); digit 0 carries PM.
      dp_next = (index_reg == 3'd2) || (index_reg == 3'd4) ||
                ((index_reg == 3'd0) && pm);
   end

   logic [6:0]            seg_reg;
   logic                  dp_reg;
   logic [NUM_DIGITS-1:0] an_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_reg <= '0;
         dp_reg  <= 1'b0;
         an_reg  <= '0;
      end else begin
         seg_reg <= seg_next;
         dp_reg  <= dp_next;
         an_reg  <= an_next;
      end
   end

   assign seg = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
   assign dp  = SEG_ACTIVE_LOW ? ~dp_reg  : dp_reg;
   assign an  = SEG_ACTIVE_LOW ? ~an_reg  : an_reg;

endmodule

// File: tb/tb_clock_display_mux.sv
module tb_clock_display_mux;

   localparam int SCAN_DIV = 4;

   logic       clock;
   logic       reset;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hr;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame_start;

   clock_display_mux #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clock       (clock),
      .reset       (reset),
      .sec         (sec),
      .min         (min),
      .hr          (hr),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int pops = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Expected {seg, dp, an} for digit k of a frame showing h:m:s.
   function automatic logic [13:0] exp_digit(input int k, input int s, input int m, input int h);
      int v, lim, hd;
      bit pm;
      logic [6:0] sg;
      logic dpx;
      logic [5:0] anx;
      pm = 1'b0;
      hd = h;
`ifdef CLOCK_DISPLAY_12H_EN
      if (h <= 23) begin
         pm = (h >= 12);
         if (h == 0) hd = 12;
         else if (h > 12) hd = h - 12;
      end
`endif
      case (k / 2)
         0: begin v = s;  lim = 59; end
         1: begin v = m;  lim = 59; end
         default: begin v = hd; lim = 23; end
      endcase
      if (v > lim) sg = 7'b1000000;
      else if (k % 2 == 0) sg = seg_of(v % 10);
      else sg = seg_of(v / 10);
      dpx = (k == 2) || (k == 4) || ((k == 0) && pm);
      anx = 6'(1 << k);
      return {sg, dpx, anx};
   endfunction

   // Scoreboard: push a frame of expected digits on frame_start, pop one
   // entry each time the enabled digit changes.
   logic [13:0] sb [$];
   logic [5:0]  prev_an;
   int          run_len;

   always @(negedge clock) begin
      if (reset) begin
         sb.delete();
         prev_an = 6'd0;
         run_len = 0;
      end else begin
         if (frame_start)
            for (int k = 0; k < 6; k++)
               sb.push_back(exp_digit(k, int'(sec), int'(min), int'(hr)));
         if (an != prev_an) begin
            if (prev_an != 6'd0)
               check("dwell", run_len, SCAN_DIV);
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd0, 32'd1);
            end else begin
               logic [13:0] e;
               e = sb.pop_front();
               pops++;
               $display("digit an=%b seg=%b dp=%b exp=%b", an, seg, dp, e);
               check("digit", {seg, dp, an}, e);
            end
            prev_an = an;
            run_len = 1;
         end else begin
            run_len++;
         end
      end
   end

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frame_start && n < 200);
      if (!frame_start) check("frame_timeout", 32'd0, 32'd1);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      @(posedge clock);
      #2;
      hr  = 5'(h);
      min = 6'(m);
      sec = 6'(s);
   endtask

   task automatic release_and_check();
      @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      check("fs_cycle1", frame_start, 1'b1);
      check("an_cycle1", an, 6'd0);
      @(negedge clock);
      check("an_cycle2", an, 6'b000001);
      check("fs_cycle2", frame_start, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      hr = 5'd13; min = 6'd45; sec = 6'd7;
      repeat (3) @(negedge clock);
      check("rst_seg", seg, 7'd0);
      check("rst_an", an, 6'd0);
      check("rst_dp", dp, 1'b0);
      check("rst_fs", frame_start, 1'b0);

      release_and_check();
      wait_frame();

      // Change seconds while digit 3 is enabled; it belongs to the next frame.
      repeat (14) @(posedge clock);
      #2;
      sec = 6'd8;
      wait_frame();
      wait_frame();

      set_time(13, 60, 8);
      wait_frame();
      wait_frame();

      set_time(23, 59, 59);
      wait_frame();
      wait_frame();

      set_time(0, 0, 0);
      wait_frame();
      wait_frame();

      // Asynchronous reset at digit 4, prescaler 2.
      set_time(11, 22, 33);
      wait_frame();
      repeat (19) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_seg", seg, 7'd0);
      check("midrst_an", an, 6'd0);
      check("midrst_dp", dp, 1'b0);
      check("midrst_fs", frame_start, 1'b0);
      repeat (2) @(negedge clock);
      release_and_check();
      wait_frame();
      wait_frame();

      set_time(0, 10, 20);
      wait_frame();
      wait_frame();
      set_time(13, 5, 6);
      wait_frame();
      wait_frame();
      set_time(12, 30, 40);
      wait_frame();
      wait_frame();
      set_time(25, 30, 40);
      wait_frame();
      wait_frame();
      repeat (3) @(negedge clock);

      check("digits_seen", 32'(pops >= 80), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
